mem_access_ctrl: RTL

- MEM-stage data-memory access controller.
- Issues load/store transactions to the data bus.
- Stalls the pipeline while an access is outstanding, then pulses suspend_finish so that hazard and forwarding logic resumes.
- Formats load data (lane select, sign/zero extension) so it can be used as the MEM-stage write data.

---
 rtl/mem_access_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: bus handshake, stall, load formatting.
// Optional MEM_ALIGN_CHK_EN: misaligned accesses skip the bus and flag misalign_err.
module mem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rstn,
    input  logic              mem_req,
    input  logic              mem_wen,
    input  logic [1:0]        mem_size,
    input  logic              mem_sext,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              suspend,
    output logic              suspend_finish,
    output logic [31:0]       ld_data,
    output logic              misalign_err,
    output logic              bus_req,
    output logic              bus_wen,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [1:0]  off_q;
    logic [3:0]  strb_d;
    logic [31:0] wdata_d;
    logic [31:0] fmt_d;
    logic        start;
    logic        mis_d;

    assign start = (state_q == IDLE) && mem_req;

    // Misalignment check on the incoming request
    always_comb begin
        mis_d = 1'b0;
        unique case (1'b1)
            mem_size == 2'b01: mis_d = mem_addr[0];
            mem_size[1]:       mis_d = |mem_addr[1:0];
            default:           mis_d = 1'b0;
        endcase
    end

`ifdef MEM_ALIGN_CHK_EN
    logic err_q;

    // Remember whether the current access was rejected as misaligned
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn)
            err_q <= 1'b0;
        else if (start)
            err_q <= mis_d;
    end

    assign misalign_err = (state_q == DONE) && err_q;
`else
    logic unused_mis;
    assign unused_mis   = mis_d;
    assign misalign_err = 1'b0;
`endif

    // Byte strobes and lane-replicated store data from the request
    always_comb begin
        strb_d  = 4'b1111;
        wdata_d = mem_wdata;
        unique case (mem_size)
            2'b00: begin
                strb_d  = 4'b0001 << mem_addr[1:0];
                wdata_d = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
                strb_d  = 4'b0011 << {mem_addr[1], 1'b0};
                wdata_d = {2{mem_wdata[15:0]}};
            end
            default: begin
                strb_d  = 4'b1111;
                wdata_d = mem_wdata;
            end
        endcase
    end

    // Lane select and sign/zero extension of read data
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b     = 8'h00;
        h     = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        fmt_d = bus_rdata;
        unique case (off_q)
            2'd0:    b = bus_rdata[7:0];
            2'd1:    b = bus_rdata[15:8];
            2'd2:    b = bus_rdata[23:16];
            default: b = bus_rdata[31:24];
        endcase
        unique case (size_q)
            2'b00:   fmt_d = sext_q ? {{24{b[7]}}, b} : {24'h0, b};
            2'b01:   fmt_d = sext_q ? {{16{h[15]}}, h} : {16'h0, h};
            default: fmt_d = bus_rdata;
        endcase
    end

    // State register
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; DONE always returns to IDLE ignoring mem_req
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mem_req) begin
`ifdef MEM_ALIGN_CHK_EN
                    state_d = mis_d ? DONE : REQ;
`else
                    state_d = REQ;
`endif
                end
            end
            REQ:     if (bus_gnt) state_d = WAIT;
            WAIT:    if (bus_ack) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Latch request fields at start; capture load result on ack
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            bus_wen   <= 1'b0;
            bus_addr  <= '0;
            bus_wstrb <= 4'h0;
            bus_wdata <= 32'h0;
            size_q    <= 2'b00;
            sext_q    <= 1'b0;
            off_q     <= 2'b00;
            ld_data   <= 32'h0;
        end else if (start) begin
            bus_wen   <= mem_wen;
            bus_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
            bus_wstrb <= strb_d;
            bus_wdata <= wdata_d;
            size_q    <= mem_size;
            sext_q    <= mem_sext;
            off_q     <= mem_addr[1:0];
`ifdef MEM_ALIGN_CHK_EN
            if (mis_d)
                ld_data <= 32'h0;
`endif
        end else if (state_q == WAIT && bus_ack) begin
            ld_data <= bus_wen ? 32'h0 : fmt_d;
        end
    end

    assign bus_req        = (state_q == REQ);
    assign suspend_finish = (state_q == DONE);
    assign suspend        = cpu_rstn &&
                            (start || state_q == REQ || state_q == WAIT);

endmodule
